updown_sweep_ctrl: RTL and testbench



---
 rtl/updown_ctrl_pkg.sv | 20 ++
 rtl/updown_sweep_ctrl_if.sv | 32 +++
 rtl/up_down_counter.sv | 20 ++
 rtl/updown_dwell_timer.sv | 36 +++
 rtl/updown_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 6 files changed

// File: rtl/updown_ctrl_pkg.sv
// rtl/updown_ctrl_pkg.sv - shared state encodings, default widths and direction constants for the sweep controller
package updown_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PRIME = 3'd2,
        ST_UP    = 3'd3,
        ST_DOWN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_DWELL = 3'd6
    } state_e;

    localparam int   DEF_WIDTH   = 4;
    localparam int   DEF_SWEEP_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// rtl/updown_sweep_ctrl_if.sv - command, status and counter-side signals of the sweep controller
interface updown_sweep_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
);
    logic               start;
    logic               stop;
    logic               hold;
    logic [WIDTH-1:0]   lo_lim;
    logic [WIDTH-1:0]   hi_lim;
    logic [SWEEP_W-1:0] num_sweeps;
    logic [WIDTH-1:0]   cnt_val;
    logic               cnt_on;
    logic               cnt_up_down;
    logic               cnt_clear;
    logic               busy;
    logic               done;
    logic               err;
    logic [SWEEP_W-1:0] sweep_cnt;

    // Controller side.
    modport slave (
        input  start, stop, hold, lo_lim, hi_lim, num_sweeps, cnt_val,
        output cnt_on, cnt_up_down, cnt_clear, busy, done, err, sweep_cnt
    );

    // Register layer / counter side.
    modport master (
        output start, stop, hold, lo_lim, hi_lim, num_sweeps, cnt_val,
        input  cnt_on, cnt_up_down, cnt_clear, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - up/down counter datapath with synchronous active-high clear
module up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on,
    input  logic             up_down,
    output logic [WIDTH-1:0] out
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (on) begin
            out <= up_down ? out + ONE : out - ONE;
        end
    end
endmodule

// File: rtl/updown_dwell_timer.sv
// rtl/updown_dwell_timer.sv - load/hold/expire down-counter timing the endpoint dwell
module updown_dwell_timer #(
    parameter int DWELL_CYC = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic hold_i,
    output logic expire_o
);
    localparam int           CW       = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Loaded with DWELL_CYC-1 so expiry lands on the last of DWELL_CYC unheld cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (!hold_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = !hold_i && (cnt_q == '0);
endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - sweeps an up/down counter lo->hi->lo num times; SWEEP_DWELL_EN adds an endpoint dwell
module updown_sweep_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SWEEP_W   = DEF_SWEEP_W,
    parameter int DWELL_CYC = 3
) (
    input  logic                clk,
    input  logic                reset,
    updown_sweep_ctrl_if.slave  bus
);
    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [SWEEP_W-1:0] ONE_S = SWEEP_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [SWEEP_W-1:0] num_q, num_d, swp_q, swp_d;
    logic               err_q, err_d, done_q, done_d;
    logic               run;
    logic [WIDTH-1:0]   lo_m1, lo_p1, hi_m1;
    logic [SWEEP_W-1:0] swp_p1;

`ifdef SWEEP_DWELL_EN
    logic dir_q, dir_d;
    logic dwell_load, dwell_hold, dwell_expire;

    assign dwell_hold = (state_q != ST_DWELL) || bus.hold;
    assign dwell_load = (state_q != ST_DWELL) && (state_d == ST_DWELL);

    updown_dwell_timer #(.DWELL_CYC(DWELL_CYC)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load_i   (dwell_load),
        .hold_i   (dwell_hold),
        .expire_o (dwell_expire)
    );
`endif

    assign lo_m1  = lo_q - ONE_W;
    assign lo_p1  = lo_q + ONE_W;
    assign hi_m1  = hi_q - ONE_W;
    assign swp_p1 = swp_q + ONE_S;
    assign run    = !bus.hold && !bus.stop;

    always_comb begin
        state_d         = state_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        num_d           = num_q;
        swp_d           = swp_q;
        err_d           = 1'b0;
        done_d          = 1'b0;
        bus.cnt_on      = 1'b0;
        bus.cnt_up_down = DIR_DOWN;
        bus.cnt_clear   = 1'b0;
        bus.busy        = (state_q != ST_IDLE);
`ifdef SWEEP_DWELL_EN
        dir_d           = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.lo_lim < bus.hi_lim) begin
                        lo_d    = bus.lo_lim;
                        hi_d    = bus.hi_lim;
                        num_d   = bus.num_sweeps;
                        swp_d   = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                bus.cnt_clear = 1'b1;
                state_d       = (lo_q != '0) ? ST_PRIME : ST_UP;
            end
            ST_PRIME: begin
                bus.cnt_up_down = DIR_UP;
                bus.cnt_on      = run;
                if (run && bus.cnt_val == lo_m1) begin
                    state_d = ST_UP;
                end
            end
            ST_UP: begin
                bus.cnt_up_down = DIR_UP;
                bus.cnt_on      = run;
                if (run && bus.cnt_val == hi_m1) begin
`ifdef SWEEP_DWELL_EN
                    state_d = ST_DWELL;
                    dir_d   = DIR_DOWN;
`else
                    state_d = ST_DOWN;
`endif
                end
            end
            ST_DOWN: begin
                bus.cnt_on = run;
                if (run && bus.cnt_val == lo_p1) begin
                    swp_d = swp_p1;
                    if (num_q != '0 && swp_p1 == num_q) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        state_d = ST_DWELL;
                        dir_d   = DIR_UP;
`else
                        state_d = ST_UP;
`endif
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef SWEEP_DWELL_EN
            ST_DWELL: begin
                if (dwell_expire) begin
                    state_d = (dir_q == DIR_UP) ? ST_UP : ST_DOWN;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over every transition above, including the completion pulse.
        if (state_q != ST_IDLE && bus.stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            num_q   <= '0;
            swp_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_DWELL_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            num_q   <= num_d;
            swp_q   <= swp_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef SWEEP_DWELL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // done shows in the first IDLE cycle, so it coincides with busy falling.
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sweep_cnt = swp_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - table-driven and directed bench for updown_sweep_ctrl paired with up_down_counter
module tb_updown_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl_if #(.WIDTH(4), .SWEEP_W(8)) bus ();

    up_down_counter #(.WIDTH(4)) u_cnt (
        .clk     (clk),
        .reset   (bus.cnt_clear),
        .on      (bus.cnt_on),
        .up_down (bus.cnt_up_down),
        .out     (bus.cnt_val)
    );

    updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8), .DWELL_CYC(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       start, hold, stop;
        logic [3:0] lo, hi;
        logic [7:0] num;
        logic       cc;
        logic [3:0] cnt;
        logic       busy, done, err, on, up, clr;
        logic [7:0] swp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic h, input logic p,
                       input logic [3:0] lo, input logic [3:0] hi, input logic [7:0] num,
                       input logic cc, input logic [3:0] cnt,
                       input logic b, input logic d, input logic e,
                       input logic o, input logic u, input logic c, input logic [7:0] sw);
        vec_t v;
        v = '{s, h, p, lo, hi, num, cc, cnt, b, d, e, o, u, c, sw};
        vq.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vq.size(); i++) begin
            bus.start      = vq[i].start;
            bus.hold       = vq[i].hold;
            bus.stop       = vq[i].stop;
            bus.lo_lim     = vq[i].lo;
            bus.hi_lim     = vq[i].hi;
            bus.num_sweeps = vq[i].num;
            #1;
            if (vq[i].cc) chk($sformatf("v%0d cnt_val", i), bus.cnt_val, vq[i].cnt);
            chk($sformatf("v%0d busy", i), bus.busy, vq[i].busy);
            chk($sformatf("v%0d done", i), bus.done, vq[i].done);
            chk($sformatf("v%0d err", i), bus.err, vq[i].err);
            chk($sformatf("v%0d cnt_on", i), bus.cnt_on, vq[i].on);
            chk($sformatf("v%0d cnt_up_down", i), bus.cnt_up_down, vq[i].up);
            chk($sformatf("v%0d cnt_clear", i), bus.cnt_clear, vq[i].clr);
            chk($sformatf("v%0d sweep_cnt", i), bus.sweep_cnt, vq[i].swp);
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic start_run(input logic [3:0] lo, input logic [3:0] hi, input logic [7:0] num);
        bus.lo_lim = lo; bus.hi_lim = hi; bus.num_sweeps = num; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] rel_exp [4];
        logic       rel_up  [4];
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.hold = 0;
        bus.lo_lim = 0; bus.hi_lim = 0; bus.num_sweeps = 0;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst err", bus.err, 0);
        chk("rst cnt_on", bus.cnt_on, 0);
        chk("rst cnt_clear", bus.cnt_clear, 0);
        chk("rst sweep_cnt", bus.sweep_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef SWEEP_DWELL_EN
        // lo=2 hi=5 num=2; start pulsed mid-run and limits changed mid-run must be ignored
        add(1,0,0, 2,5,2, 0,0, 0,0,0,0,0,0, 0);
        add(0,0,0, 2,5,2, 0,0, 1,0,0,0,0,1, 0);
        add(0,0,0, 2,5,2, 1,0, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,5,2, 1,1, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,5,2, 1,2, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,5,2, 1,3, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,5,2, 1,4, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,5,2, 1,5, 1,0,0,1,0,0, 0);
        add(1,0,0, 2,5,2, 1,4, 1,0,0,1,0,0, 0);
        add(0,0,0, 2,5,2, 1,3, 1,0,0,1,0,0, 0);
        add(0,0,0, 0,9,7, 1,2, 1,0,0,1,1,0, 1);
        add(0,0,0, 0,9,7, 1,3, 1,0,0,1,1,0, 1);
        add(0,0,0, 0,9,7, 1,4, 1,0,0,1,1,0, 1);
        add(0,0,0, 0,9,7, 1,5, 1,0,0,1,0,0, 1);
        add(0,0,0, 0,9,7, 1,4, 1,0,0,1,0,0, 1);
        add(0,0,0, 0,9,7, 1,3, 1,0,0,1,0,0, 1);
        add(0,0,0, 0,9,7, 1,2, 1,0,0,0,0,0, 2);
        add(0,0,0, 0,9,7, 1,2, 0,1,0,0,0,0, 2);
        add(0,0,0, 0,9,7, 1,2, 0,0,0,0,0,0, 2);
        // lo=0 hi=1 num=3: no PRIME, one-cycle UP/DOWN
        add(1,0,0, 0,1,3, 1,2, 0,0,0,0,0,0, 2);
        add(0,0,0, 0,1,3, 1,2, 1,0,0,0,0,1, 0);
        add(0,0,0, 0,1,3, 1,0, 1,0,0,1,1,0, 0);
        add(0,0,0, 0,1,3, 1,1, 1,0,0,1,0,0, 0);
        add(0,0,0, 0,1,3, 1,0, 1,0,0,1,1,0, 1);
        add(0,0,0, 0,1,3, 1,1, 1,0,0,1,0,0, 1);
        add(0,0,0, 0,1,3, 1,0, 1,0,0,1,1,0, 2);
        add(0,0,0, 0,1,3, 1,1, 1,0,0,1,0,0, 2);
        add(0,0,0, 0,1,3, 1,0, 1,0,0,0,0,0, 3);
        add(0,0,0, 0,1,3, 1,0, 0,1,0,0,0,0, 3);
        add(0,0,0, 0,1,3, 1,0, 0,0,0,0,0,0, 3);
        // lo=hi=6: rejected start
        add(1,0,0, 6,6,1, 1,0, 0,0,0,0,0,0, 3);
        add(0,0,0, 6,6,1, 1,0, 0,0,1,0,0,0, 3);
        add(0,0,0, 6,6,1, 1,0, 0,0,0,0,0,0, 3);
        run_table();

        // hold in UP at cnt_val=4
        start_run(1, 7, 0);
        n = 0;
        while (!(bus.cnt_val == 4 && bus.cnt_up_down == 1'b1 && bus.busy) && n < 40) begin
            @(negedge clk); n++;
        end
        chk("hold reach cnt 4", (n < 40), 1);
        bus.hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d cnt_val", k), bus.cnt_val, 4);
            chk($sformatf("hold%0d cnt_on", k), bus.cnt_on, 0);
            @(negedge clk);
        end
        bus.hold = 1'b0;
        #1 chk("release cnt_on", bus.cnt_on, 1);
        rel_exp = '{4'd5, 4'd6, 4'd7, 4'd6};
        rel_up  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("release%0d cnt_val", k), bus.cnt_val, rel_exp[k]);
            chk($sformatf("release%0d cnt_up_down", k), bus.cnt_up_down, rel_up[k]);
        end

        // stop in DOWN at cnt_val=3 during the second sweep
        n = 0;
        while (!(bus.sweep_cnt == 1 && bus.cnt_val == 3 && bus.cnt_up_down == 1'b0 && bus.busy) && n < 60) begin
            @(negedge clk); n++;
        end
        chk("stop reach cnt 3", (n < 60), 1);
        bus.stop = 1'b1;
        #1;
        chk("stop cnt_on", bus.cnt_on, 0);
        chk("stop busy same cycle", bus.busy, 1);
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop busy next", bus.busy, 0);
        chk("stop cnt_val frozen", bus.cnt_val, 3);
        chk("stop done", bus.done, 0);
        chk("stop sweep_cnt kept", bus.sweep_cnt, 1);
        @(negedge clk);
        chk("stop done later", bus.done, 0);

        // asynchronous reset mid-UP
        start_run(1, 7, 0);
        n = 0;
        while (!(bus.cnt_val == 4 && bus.cnt_up_down == 1'b1 && bus.busy) && n < 40) begin
            @(negedge clk); n++;
        end
        chk("rst reach cnt 4", (n < 40), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", bus.busy, 0);
        chk("arst cnt_on", bus.cnt_on, 0);
        chk("arst cnt_up_down", bus.cnt_up_down, 0);
        chk("arst cnt_clear", bus.cnt_clear, 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst cnt_val kept", bus.cnt_val, 4);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst idle busy", bus.busy, 0);
`else
        // dwell: lo=2 hi=4 num=1, three extra cycles at hi, none at final lo
        add(1,0,0, 2,4,1, 0,0, 0,0,0,0,0,0, 0);
        add(0,0,0, 2,4,1, 0,0, 1,0,0,0,0,1, 0);
        add(0,0,0, 2,4,1, 1,0, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,4,1, 1,1, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,4,1, 1,2, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,4,1, 1,3, 1,0,0,1,1,0, 0);
        add(0,0,0, 2,4,1, 1,4, 1,0,0,0,0,0, 0);
        add(0,0,0, 2,4,1, 1,4, 1,0,0,0,0,0, 0);
        add(0,0,0, 2,4,1, 1,4, 1,0,0,0,0,0, 0);
        add(0,0,0, 2,4,1, 1,4, 1,0,0,1,0,0, 0);
        add(0,0,0, 2,4,1, 1,3, 1,0,0,1,0,0, 0);
        add(0,0,0, 2,4,1, 1,2, 1,0,0,0,0,0, 1);
        add(0,0,0, 2,4,1, 1,2, 0,1,0,0,0,0, 1);
        add(0,0,0, 2,4,1, 1,2, 0,0,0,0,0,0, 1);
        run_table();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
